tdm_demux8: RTL

Time-division demultiplexer: the receive end of the 8-slot serial link that our 8:1 select mux drives when its select is stepped by a slot counter. It accepts one channel sample per valid cycle, aligns to a frame-sync marker, steers each sample into its slot, and publishes all eight slots in parallel with a one-cycle valid strobe once a full frame is collected. It sits between the serial link input and the parallel channel consumers.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_ctr.sv | 25 ++
 rtl/tdm_demux8.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 8-slot TDM demultiplexer.
package tdm_pkg;
   localparam int NUM_SLOTS      = 8;
   localparam int SLOT_W         = 3;
   localparam int ERRCNT_W       = 8;
   localparam int MISALIGN_LIMIT = 3;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: synchronous clear, load-to-1 and increment-enable; wraps mod 8.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot
);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (load) begin
         slot <= SLOT_W'(1);
      end else if (inc) begin
         slot <= slot + 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM receiver: aligns on Frame_Sync, collects a shadow frame, publishes it on Out.
// Optional sync-error counter and forced re-hunt enabled by TDM_DEMUX_ERRCNT_EN.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int CHAN_W = 1
) (
   input  logic                        Clk,
   input  logic                        Rst_n,
   input  logic [CHAN_W-1:0]           In,
   input  logic                        In_Valid,
   input  logic                        Frame_Sync,
   output logic [NUM_SLOTS*CHAN_W-1:0] Out,
   output logic                        Out_Valid,
   output logic [SLOT_W-1:0]           Sel,
   output logic                        Locked
`ifdef TDM_DEMUX_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0]         Sync_Err_Cnt
`endif
);

   state_t                        state, state_nxt;
   logic                          ctr_clr, ctr_load, ctr_inc;
   logic                          wr_en, publish;
   logic [SLOT_W-1:0]             wr_slot;
   logic [NUM_SLOTS*CHAN_W-1:0]   shadow;
`ifdef TDM_DEMUX_ERRCNT_EN
   logic                          misalign, force_hunt;
   logic [1:0]                    miss_cnt;
   logic [ERRCNT_W-1:0]           err_cnt;
`endif

   tdm_slot_ctr u_slot_ctr (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .clr   (ctr_clr),
      .load  (ctr_load),
      .inc   (ctr_inc),
      .slot  (Sel)
   );

   always_comb begin
      state_nxt = state;
      ctr_clr   = 1'b0;
      ctr_load  = 1'b0;
      ctr_inc   = 1'b0;
      wr_en     = 1'b0;
      wr_slot   = Sel;
      publish   = 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
      misalign   = 1'b0;
      force_hunt = 1'b0;
`endif
      if (In_Valid) begin
         case (state)
            HUNT: begin
               if (Frame_Sync) begin
                  wr_en     = 1'b1;
                  wr_slot   = '0;
                  ctr_load  = 1'b1;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (Frame_Sync && (Sel != '0)) begin
                  // Misaligned sync: drop the partial frame and restart at slot 0.
`ifdef TDM_DEMUX_ERRCNT_EN
                  misalign = 1'b1;
                  if (miss_cnt == 2'(MISALIGN_LIMIT - 1)) begin
                     force_hunt = 1'b1;
                     ctr_clr    = 1'b1;
                     state_nxt  = HUNT;
                  end else begin
                     wr_en    = 1'b1;
                     wr_slot  = '0;
                     ctr_load = 1'b1;
                  end
`else
                  wr_en    = 1'b1;
                  wr_slot  = '0;
                  ctr_load = 1'b1;
`endif
               end else begin
                  wr_en   = 1'b1;
                  ctr_inc = 1'b1;
                  publish = (Sel == SLOT_W'(NUM_SLOTS - 1));
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= HUNT;
         shadow    <= '0;
         Out       <= '0;
         Out_Valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         Out_Valid <= publish;
         if (wr_en) begin
            shadow[wr_slot*CHAN_W +: CHAN_W] <= In;
         end
         // The slot-7 sample bypasses the shadow so Out updates on its accepting edge.
         if (publish) begin
            Out <= {In, shadow[(NUM_SLOTS-1)*CHAN_W-1:0]};
         end
      end
   end

   assign Locked = (state == RUN);

`ifdef TDM_DEMUX_ERRCNT_EN
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         err_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (misalign && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
         if (publish || force_hunt) begin
            miss_cnt <= '0;
         end else if (misalign) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end

   assign Sync_Err_Cnt = err_cnt;
`endif

endmodule
